// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// Conditions the raw keyboard clock/data lines (two-flop synchroniser plus a
// glitch filter on the clock), then deserialises the 11-bit frame
// (start, 8 data bits LSB first, odd parity, stop). Each completed frame
// produces exactly one registered single-cycle pulse: rx_valid, parity_err
// or frame_err. A mid-frame stall longer than TIMEOUT_CYCLES aborts the frame
// with a frame_err pulse.
//
// Output strobe semantics: rx_valid, parity_err and frame_err are one-cycle
// pulses with no ready/acknowledge path; the consumer must sample them in the
// cycle they are high. rx_data is updated in the same cycle as rx_valid and
// then holds its value until the next good frame (or reset).

module ps2_frame_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_pc2,
   input  logic       data_pc2,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   // Frame-level states.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // Terminal counts. FILTER_LEN fits 8 bits, TIMEOUT_CYCLES fits 20 bits.
   localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
   localparam logic [19:0] TO_MAX   = 20'(TIMEOUT_CYCLES - 1);

   // Synchroniser flops (idle level of both PS/2 lines is high).
   logic        clk_s1;
   logic        clk_s2;
   logic        dat_s1;
   logic        dat_s2;

   // Glitch filter on the synchronised clock.
   logic [7:0]  filt_cnt;
   logic        filt_clk;
   logic        filt_prev;
   logic        fall;

   // Frame deserialiser.
   logic [1:0]  state;
   logic [2:0]  bitcnt;
   logic [7:0]  shreg;
   logic        par_bit;
   logic        parity_ok;

   // Mid-frame stall detection.
   logic [19:0] to_cnt;
   logic        timeout;

   // Two-flop synchronisers for the asynchronous PS/2 lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= clk_pc2;
         clk_s2 <= clk_s1;
         dat_s1 <= data_pc2;
         dat_s2 <= dat_s1;
      end
   end

   // Filtered clock follows the synced clock only after FILTER_LEN
   // consecutive differing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_cnt <= 8'd0;
         filt_clk <= 1'b1;
      end else if (clk_s2 != filt_clk) begin
         if (filt_cnt == FILT_MAX) begin
            filt_clk <= clk_s2;
            filt_cnt <= 8'd0;
         end else begin
            filt_cnt <= filt_cnt + 8'd1;
         end
      end else begin
         filt_cnt <= 8'd0;
      end
   end

   // Delayed copy of the filtered clock for falling-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_prev <= 1'b1;
      end else begin
         filt_prev <= filt_clk;
      end
   end

   // One-cycle strobe on each filtered 1->0 transition; the data bit is
   // dat_s2 in this same cycle.
   assign fall = filt_prev & ~filt_clk;

   // Odd parity over data plus parity bit: total number of ones must be odd.
   assign parity_ok = ^{shreg, par_bit};

   // A stall timeout only counts when no strobe arrives in the same cycle.
   assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_MAX);

   // Stall counter: held at zero in IDLE, cleared by every strobe mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= 20'd0;
      end else if (state == ST_IDLE || fall || timeout) begin
         to_cnt <= 20'd0;
      end else begin
         to_cnt <= to_cnt + 20'd1;
      end
   end

   // Frame FSM, shift register and registered result pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bitcnt     <= 3'd0;
         shreg      <= 8'h00;
         par_bit    <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         if (timeout) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               ST_IDLE: begin
                  // A high data line on a falling edge is not a start bit;
                  // ignore it quietly.
                  if (!dat_s2) begin
                     state  <= ST_DATA;
                     bitcnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  // Right shift: the first (LSB) bit ends up in shreg[0].
                  shreg  <= {dat_s2, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  par_bit <= dat_s2;
                  state   <= ST_STOP;
               end
               ST_STOP: begin
                  // A bad stop bit outranks a bad parity bit.
                  if (!dat_s2) begin
                     frame_err <= 1'b1;
                  end else if (!parity_ok) begin
                     parity_err <= 1'b1;
                  end else begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed-vector bench for ps2_frame_rx.
// Drivers emulate a PS/2 device (50-cycle half period, data changed in the
// middle of the high phase). Expected pulses are queued before each frame;
// a negedge monitor pops and compares whenever the DUT pulses.

module tb_ps2_frame_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 2000;
   localparam int HALF       = 50;

   // Pulse encoding: {rx_valid, parity_err, frame_err, data}.
   localparam logic [2:0] K_VALID  = 3'b100;
   localparam logic [2:0] K_PARITY = 3'b010;
   localparam logic [2:0] K_FRAME  = 3'b001;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_pc2;
   logic       data_pc2;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   logic [10:0] exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned cyc           = 0;
   int unsigned pulse_cnt     = 0;
   int unsigned busy_hits     = 0;
   int unsigned last_pulse_cyc = 0;
   int unsigned last_fall_cyc  = 0;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_pc2    (clk_pc2),
      .data_pc2   (data_pc2),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so the run can never hang.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded 2 ms, got no summary, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every pulse pops one expected entry.
   always @(negedge clk) begin
      logic [10:0] act;
      if (busy) busy_hits++;
      if (!rst && (rx_valid || parity_err || frame_err)) begin
         pulse_cnt++;
         last_pulse_cyc = cyc;
         act = {rx_valid, parity_err, frame_err, (rx_valid ? rx_data : 8'h00)};
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(act), 32'h0);
         end else begin
            check("pulse", 32'(act), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   // Send the first n bits of a frame, LSB (start bit) first.
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         wait_cyc(HALF / 2);
         data_pc2 = f[i];
         wait_cyc(HALF / 2);
         clk_pc2 = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(HALF);
         clk_pc2 = 1'b1;
      end
      wait_cyc(HALF / 2);
      data_pc2 = 1'b1;
   endtask

   // Send a full frame and check exactly one pulse followed, busy back low.
   task automatic run_frame(input string name, input logic [10:0] f);
      int unsigned pc0;
      pc0 = pulse_cnt;
      send_bits(f, 11);
      wait_cyc(60);
      check({name, "_pulse_count"}, pulse_cnt - pc0, 1);
      check({name, "_busy_idle"}, 32'(busy), 0);
   endtask

   // Drive a low pulse on the PS/2 clock while idle.
   task automatic glitch(input string name, input int len);
      int unsigned hits0;
      int unsigned pc0;
      hits0 = busy_hits;
      pc0   = pulse_cnt;
      clk_pc2 = 1'b0;
      wait_cyc(len);
      clk_pc2 = 1'b1;
      wait_cyc(30);
      check({name, "_busy_cycles"}, busy_hits - hits0, 0);
      check({name, "_pulses"}, pulse_cnt - pc0, 0);
   endtask

   initial begin
      int unsigned pc0;
      int unsigned diff;
      rst      = 1'b1;
      clk_pc2  = 1'b1;
      data_pc2 = 1'b1;
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(2);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_busy", 32'(busy), 0);
      check("reset_pulses", 32'({rx_valid, parity_err, frame_err}), 0);

      // Good frame 0x1C.
      exp_q.push_back({K_VALID, 8'h1C});
      run_frame("good_1c", frame(8'h1C, 1'b0, 1'b1));
      check("good_1c_rx_data", 32'(rx_data), 32'h1C);

      // 0x1C with wrong parity: parity error, data held.
      exp_q.push_back({K_PARITY, 8'h00});
      run_frame("bad_par", frame(8'h1C, 1'b1, 1'b1));
      check("bad_par_rx_data_held", 32'(rx_data), 32'h1C);

      // 0x5A with stop bit 0: frame error only.
      exp_q.push_back({K_FRAME, 8'h00});
      run_frame("bad_stop", frame(8'h5A, 1'b1, 1'b0));
      check("bad_stop_rx_data_held", 32'(rx_data), 32'h1C);

      // Good 0xF0.
      exp_q.push_back({K_VALID, 8'hF0});
      run_frame("good_f0", frame(8'hF0, 1'b1, 1'b1));
      check("good_f0_rx_data", 32'(rx_data), 32'hF0);

      // Clock glitches while idle.
      glitch("glitch6", 6);
      glitch("glitch9", 9);

      // Timeout: start plus 4 data bits, then clock held high.
      exp_q.push_back({K_FRAME, 8'h00});
      pc0 = pulse_cnt;
      send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
      for (int k = 0; k < 2500 && pulse_cnt == pc0; k++) @(negedge clk);
      check("timeout_fired", pulse_cnt - pc0, 1);
      diff = last_pulse_cyc - last_fall_cyc;
      vectors++;
      if (diff < (2 + FILTER_LEN + TIMEOUT - 1) || diff > (2 + FILTER_LEN + TIMEOUT + 1)) begin
         miscompares++;
         $display("FAIL timeout_delay: got %0d cycles from last raw fall, required %0d +/-1",
                  diff, 2 + FILTER_LEN + TIMEOUT);
      end
      wait_cyc(2);
      check("timeout_busy", 32'(busy), 0);
      check("timeout_rx_data_held", 32'(rx_data), 32'hF0);

      exp_q.push_back({K_VALID, 8'h1C});
      run_frame("after_to_1c", frame(8'h1C, 1'b0, 1'b1));
      check("after_to_rx_data", 32'(rx_data), 32'h1C);

      // Reset after start plus 5 data bits.
      pc0 = pulse_cnt;
      send_bits(frame(8'h5A, 1'b1, 1'b1), 6);
      check("midframe_busy", 32'(busy), 1);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      wait_cyc(60);
      check("rst_no_pulses", pulse_cnt - pc0, 0);

      exp_q.push_back({K_VALID, 8'h5A});
      run_frame("after_rst_5a", frame(8'h5A, 1'b1, 1'b1));
      check("after_rst_rx_data", 32'(rx_data), 32'h5A);

      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
